pwr_domain_seq: RTL and testbench

PWR_DOMAIN_SEQ -- requirements
Module: pwr_domain_seq

---
 rtl/pwr_domain_seq.sv | 78 +++++++
 tb/tb_pwr_domain_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pwr_domain_seq.sv
// pwr_domain_seq: power-gating sequencer for the gated ALU domain, ordering
// switch enable, isolation, retention save/restore and clock gating.
module pwr_domain_seq #(
   parameter int RAMP_CYC = 4,
   parameter int OFF_CYC  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pwr_req,
   output logic       sw_en,
   output logic       iso_en,
   output logic       clk_en,
   output logic       ret_save,
   output logic       ret_restore,
   output logic       pwr_ack,
   output logic       busy,
   output logic [2:0] state,
   output logic [7:0] wake_count
);
   typedef enum logic [3:0] {
      OFF      = 4'd0,
      PWR_UP   = 4'd1,
      RESTORE  = 4'd2,
      DEISO    = 4'd3,
      ON       = 4'd4,
      CLK_STOP = 4'd5,
      ISO      = 4'd6,
      SAVE     = 4'd7,
      PWR_DN   = 4'd8
   } st_t;
   st_t        st, st_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       ret_valid;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= OFF;
         cnt        <= 4'd0;
         ret_valid  <= 1'b0;
         wake_count <= 8'd0;
      end else begin
         st         <= st_nxt;
         cnt        <= cnt_nxt;
         ret_valid  <= ret_valid | (st == SAVE);
         wake_count <= (st == DEISO && wake_count != 8'hff) ? wake_count + 8'd1 : wake_count;
      end
   end
   // pwr_req is only looked at in OFF and ON, so sequences cannot be aborted
   always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt - 4'd1;
      case (st)
         OFF: if (pwr_req) begin
            st_nxt  = PWR_UP;
            cnt_nxt = 4'(RAMP_CYC - 1);
         end
         PWR_UP:   if (cnt == 4'd0) st_nxt = ret_valid ? RESTORE : DEISO;
         RESTORE:  st_nxt = DEISO;
         DEISO:    st_nxt = ON;
         ON:       if (!pwr_req) st_nxt = CLK_STOP;
         CLK_STOP: st_nxt = ISO;
         ISO:      st_nxt = SAVE;
         SAVE: begin
            st_nxt  = PWR_DN;
            cnt_nxt = 4'(OFF_CYC - 1);
         end
         PWR_DN:   if (cnt == 4'd0) st_nxt = OFF;
         default:  st_nxt = OFF;
      endcase
   end
   assign sw_en       = !(st == OFF || st == PWR_DN);
   assign iso_en      = st inside {OFF, PWR_UP, RESTORE, ISO, SAVE, PWR_DN};
   assign clk_en      = st == ON;
   assign pwr_ack     = st == ON;
   assign ret_save    = st == SAVE;
   assign ret_restore = st == RESTORE;
   assign busy        = !(st == OFF || st == ON);
   assign state       = (st == PWR_DN) ? 3'd0 : st[2:0];
endmodule

// File: tb/tb_pwr_domain_seq.sv
// tb_pwr_domain_seq: scoreboard bench; stimulus queues each expected output
// vector change with its hold time, a negedge monitor pops and compares.
module tb_pwr_domain_seq;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pwr_req = 1'b0;
   logic       sw_en, iso_en, clk_en, ret_save, ret_restore, pwr_ack, busy;
   logic [2:0] state;
   logic [7:0] wake_count;

   pwr_domain_seq #(.RAMP_CYC(4), .OFF_CYC(3)) dut (
      .clk(clk), .reset(reset), .pwr_req(pwr_req),
      .sw_en(sw_en), .iso_en(iso_en), .clk_en(clk_en),
      .ret_save(ret_save), .ret_restore(ret_restore),
      .pwr_ack(pwr_ack), .busy(busy), .state(state), .wake_count(wake_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] v;
      logic [7:0] w;
      int         d;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_wake = 8'd0;
   bit         exp_rv = 1'b0;

   // {state, sw_en, iso_en, clk_en, ret_save, ret_restore, pwr_ack, busy}
   // 8 stands for PWR_DN, which reports state code 0
   function automatic logic [9:0] ev(input int s);
      case (s)
         0:       return {3'd0, 7'b0100000};
         1:       return {3'd1, 7'b1100001};
         2:       return {3'd2, 7'b1100101};
         3:       return {3'd3, 7'b1000001};
         4:       return {3'd4, 7'b1010010};
         5:       return {3'd5, 7'b1000001};
         6:       return {3'd6, 7'b1100001};
         7:       return {3'd7, 7'b1101001};
         default: return {3'd0, 7'b0100001};
      endcase
   endfunction

   // d = cycles the previous vector must have lasted (0 = don't care)
   task automatic push(input int s, input int d);
      exp_t e;
      e.v = ev(s);
      e.w = exp_wake;
      e.d = d;
      q.push_back(e);
   endtask

   logic [9:0] prev_v;
   logic [7:0] prev_w;
   bit         first = 1'b1;
   int         dur = 0;
   exp_t       got;

   always @(negedge clk) begin
      checks++;
      if ((clk_en && iso_en) || (!sw_en && !iso_en) ||
          (ret_save && (clk_en || !iso_en)) || (ret_restore && (clk_en || !iso_en))) begin
         errors++;
         $display("FAIL invariant at %0t: sw_en=%b iso_en=%b clk_en=%b ret_save=%b ret_restore=%b",
                  $time, sw_en, iso_en, clk_en, ret_save, ret_restore);
      end
      if (first || {state, sw_en, iso_en, clk_en, ret_save, ret_restore, pwr_ack, busy} !== prev_v ||
          wake_count !== prev_w) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected change at %0t: vec=%b wake_count=%0d, required no change",
                     $time, {state, sw_en, iso_en, clk_en, ret_save, ret_restore, pwr_ack, busy}, wake_count);
         end else begin
            got = q.pop_front();
            if ({state, sw_en, iso_en, clk_en, ret_save, ret_restore, pwr_ack, busy} !== got.v ||
                wake_count !== got.w || (got.d != 0 && dur != got.d)) begin
               errors++;
               $display("FAIL sequence at %0t: vec=%b wake_count=%0d prev_hold=%0d, required vec=%b wake_count=%0d prev_hold=%0d",
                        $time, {state, sw_en, iso_en, clk_en, ret_save, ret_restore, pwr_ack, busy},
                        wake_count, dur, got.v, got.w, got.d);
            end
         end
         first  = 1'b0;
         prev_v = {state, sw_en, iso_en, clk_en, ret_save, ret_restore, pwr_ack, busy};
         prev_w = wake_count;
         dur    = 1;
      end else dur++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input logic ack, input string nm);
      int n = 0;
      while ((pwr_ack !== ack || busy !== 1'b0) && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 60) begin
         errors++;
         $display("FAIL %s timeout: pwr_ack=%b busy=%b, required pwr_ack=%b busy=0", nm, pwr_ack, busy, ack);
      end
   endtask

   task automatic wake_exp();
      push(1, 0);
      if (exp_rv) begin
         push(2, 4);
         push(3, 1);
      end else push(3, 4);
      if (exp_wake != 8'hff) exp_wake++;
      push(4, 1);
   endtask

   task automatic sleep_exp(input int on_hold);
      push(5, on_hold);
      push(6, 1);
      push(7, 1);
      push(8, 1);
      push(0, 3);
      exp_rv = 1'b1;
   endtask

   task automatic wake();
      wake_exp();
      pwr_req = 1'b1;
      wait_idle(1'b1, "wake");
   endtask

   task automatic sleep();
      sleep_exp(0);
      pwr_req = 1'b0;
      wait_idle(1'b0, "sleep");
   endtask

   initial begin
      push(0, 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();
      // cold wake, sleep, warm wake, sleep
      wake();
      sleep();
      wake();
      sleep();
      // one-cycle request glitch: full wake, ON for exactly one cycle, full sleep
      wake_exp();
      sleep_exp(1);
      pwr_req = 1'b1;
      tick();
      pwr_req = 1'b0;
      wait_idle(1'b0, "glitch");
      // reset in the middle of PWR_UP
      push(1, 0);
      pwr_req = 1'b1;
      tick();
      tick();
      exp_wake = 8'd0;
      exp_rv   = 1'b0;
      push(0, 1);
      reset   = 1'b1;
      pwr_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      wake();
      sleep();
      // wake_count saturation
      for (int i = 0; i < 260; i++) begin
         wake();
         sleep();
      end
      repeat (5) tick();
      checks++;
      if (q.size() != 0 || exp_wake != 8'hff) begin
         errors++;
         $display("FAIL drain: pending=%0d exp_wake=%0d, required pending=0 exp_wake=255", q.size(), exp_wake);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
